// File: rtl/panda_pkg.sv
// Shared types for the Panda compare unit: op encoding, FSM states and the
// chunk-index width helper.
package panda_pkg;

   typedef enum logic [2:0] {
      OpEq  = 3'd0,
      OpNe  = 3'd1,
      OpLt  = 3'd2,
      OpGe  = 3'd3,
      OpMin = 3'd4,
      OpMax = 3'd5
   } cmp_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_e;

   // A single-chunk configuration still needs a 1-bit index register.
   function automatic int unsigned idx_width(input int unsigned num_chunks);
      return (num_chunks > 1) ? $clog2(num_chunks) : 1;
   endfunction

endpackage

// File: rtl/panda_cmp_chunk.sv
// Combinational compare of one ChunkWidth-bit slice. The sign-bit rule only
// applies to the most significant chunk.
module panda_cmp_chunk #(
   parameter int unsigned ChunkWidth = 8
) (
   input  logic [ChunkWidth-1:0] a,
   input  logic [ChunkWidth-1:0] b,
   input  logic                  is_top,
   input  logic                  sign,
   output logic                  chunk_eq,
   output logic                  chunk_lt
);

   logic msb_differs;

   always_comb begin
      msb_differs = is_top && sign && (a[ChunkWidth-1] != b[ChunkWidth-1]);
      chunk_eq    = (a == b);
      // Negative operand (MSB set) is the smaller one when signs differ.
      chunk_lt    = msb_differs ? a[ChunkWidth-1] : (a < b);
   end

endmodule

// File: rtl/panda_cmp_iter.sv
// Iterative MSB-first compare unit with valid/ready handshake, flush and min/max ops.
// Define PANDA_CMP_EARLY_EXIT_EN to leave SCAN at the first differing chunk.
module panda_cmp_iter
   import panda_pkg::*;
#(
   parameter int unsigned Width      = 32,
   parameter int unsigned ChunkWidth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   input  logic [2:0]       op_i,
   input  logic             sign_i,
   input  logic             flush_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [Width-1:0] result_o,
   output logic             is_equal_o,
   output logic             is_less_o
);

   localparam int unsigned NumChunks = Width / ChunkWidth;
   localparam int unsigned IdxW      = idx_width(NumChunks);
   localparam logic [IdxW-1:0] TopIdx = IdxW'(NumChunks - 1);

   cmp_state_e       state_q;
   logic [IdxW-1:0]  idx_q;
   logic [Width-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic             sign_q;
   logic             decided_q, less_q;
   logic             valid_q, eq_q, lt_q;
   logic [Width-1:0] result_q;

   logic [ChunkWidth-1:0] chunk_a, chunk_b;
   logic                  chunk_eq, chunk_lt;
   logic                  fin_eq, fin_less, scan_last;
   logic [Width-1:0]      res;

   assign chunk_a = a_q[idx_q*ChunkWidth +: ChunkWidth];
   assign chunk_b = b_q[idx_q*ChunkWidth +: ChunkWidth];

   panda_cmp_chunk #(
      .ChunkWidth (ChunkWidth)
   ) u_chunk (
      .a        (chunk_a),
      .b        (chunk_b),
      .is_top   (idx_q == TopIdx),
      .sign     (sign_q),
      .chunk_eq (chunk_eq),
      .chunk_lt (chunk_lt)
   );

   // A decision latched on an earlier chunk wins over the current one.
   always_comb begin
      fin_eq   = !decided_q && chunk_eq;
      fin_less = decided_q ? less_q : (!chunk_eq && chunk_lt);
`ifdef PANDA_CMP_EARLY_EXIT_EN
      scan_last = !chunk_eq || (idx_q == '0);
`else
      scan_last = (idx_q == '0);
`endif
   end

   always_comb begin
      res = '0;
      case (op_q)
         OpEq:    res[0] = fin_eq;
         OpNe:    res[0] = !fin_eq;
         OpLt:    res[0] = fin_less;
         OpGe:    res[0] = !fin_less;
         OpMin:   res    = fin_less ? a_q : b_q;
         OpMax:   res    = fin_less ? b_q : a_q;
         default: res    = '0;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         sign_q    <= 1'b0;
         decided_q <= 1'b0;
         less_q    <= 1'b0;
         valid_q   <= 1'b0;
         eq_q      <= 1'b0;
         lt_q      <= 1'b0;
         result_q  <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  a_q       <= a_i;
                  b_q       <= b_i;
                  op_q      <= op_i;
                  sign_q    <= sign_i;
                  idx_q     <= TopIdx;
                  decided_q <= 1'b0;
                  less_q    <= 1'b0;
                  state_q   <= SCAN;
               end
            end
            SCAN: begin
               if (!decided_q && !chunk_eq) begin
                  decided_q <= 1'b1;
                  less_q    <= chunk_lt;
               end
               if (idx_q != '0) idx_q <= idx_q - IdxW'(1);
               if (scan_last) begin
                  state_q  <= DONE;
                  valid_q  <= 1'b1;
                  result_q <= res;
                  eq_q     <= fin_eq;
                  lt_q     <= fin_less;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state_q <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_o    = (state_q == IDLE);
   assign valid_o    = valid_q;
   assign result_o   = result_q;
   assign is_equal_o = eq_q;
   assign is_less_o  = lt_q;

endmodule
